frac_reduce: RTL and testbench

Reduces a fraction num/den to lowest terms by dividing both operands by their greatest common divisor. Sits directly downstream of the gcd stage: it takes that stage's result as `g` together with the original operand pair, which upstream logic holds alongside it. The block runs two restoring shift-subtract dividers in lockstep that share the divisor `g`. It uses a valid/ready handshake on both sides and flags any divisor that is zero or does not divide both operands.

---
 rtl/frac_reduce.sv | 146 ++++++++++++++
 tb/tb_frac_reduce.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_reduce.sv
// frac_reduce: divides num and den by a shared divisor g (the gcd-stage
// result) using two restoring shift-subtract dividers in lockstep.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   num, den, g         operands, sampled on the accept edge
//   in_valid/in_ready   input handshake (in_ready high only in IDLE)
//   num_q, den_q, err   results; err = g==0 or a nonzero remainder
//   out_valid/out_ready output handshake (out_valid high only in DONE)

// One restoring division step for one lane. The shifted remainder and the
// compare/subtract are WIDTH+1 bits, so g close to 2^WIDTH-1 cannot overflow.
module frac_reduce_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_g,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_sh;
  logic           w_ge;
  // A restored remainder is always below g, so its top bit never feeds
  // the next shift.
  logic           w_unused;

  assign w_unused = i_r[WIDTH];
  assign w_sh     = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_ge     = (w_sh >= {1'b0, i_g});
  assign o_r      = w_ge ? (w_sh - {1'b0, i_g}) : w_sh;
  assign o_q      = {i_q[WIDTH-2:0], w_ge};
endmodule

module frac_reduce #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  input  logic [WIDTH-1:0] g,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] num_q,
  output logic [WIDTH-1:0] den_q,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NUM_LANES = 2;  // lane 0 = num, lane 1 = den
  localparam int CW        = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                          r_state;
  logic                                r_in_ready;
  logic [CW-1:0]                       r_cnt;
  logic [WIDTH-1:0]                    r_g;
  logic                                r_err;
  logic [NUM_LANES-1:0][WIDTH:0]       r_rem;
  logic [NUM_LANES-1:0][WIDTH-1:0]     r_q;
  logic [NUM_LANES-1:0][WIDTH:0]       w_rem_nxt;
  logic [NUM_LANES-1:0][WIDTH-1:0]     w_q_nxt;
  logic                                w_accept;
  logic                                w_last;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      frac_reduce_step #(.WIDTH(WIDTH)) u_step (
        .i_r (r_rem[l]),
        .i_q (r_q[l]),
        .i_g (r_g),
        .o_r (w_rem_nxt[l]),
        .o_q (w_q_nxt[l])
      );
    end
  endgenerate

  // in_ready is its own register so it is low during reset and the first
  // cycle after, and never depends combinationally on any input.
  assign w_accept = in_valid && r_in_ready;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
      r_g        <= '0;
      r_err      <= 1'b0;
      r_rem      <= '0;
      r_q        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_q        <= {den, num};
            if (g == '0) begin
              // Nothing to divide by: pass operands through, flag error.
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_g     <= g;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_err   <= 1'b0;
              r_state <= S_DIV;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_err   <= (|w_rem_nxt[0]) || (|w_rem_nxt[1]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign num_q     = r_q[0];
  assign den_q     = r_q[1];
  assign err       = r_err;
endmodule

// File: tb/tb_frac_reduce.sv
module tb_frac_reduce;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] num = '0, den = '0, g = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, err;
  logic [7:0] num_q, den_q;

  int total = 0;
  int bad   = 0;

  frac_reduce #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .num(num), .den(den), .g(g),
    .in_valid(in_valid), .in_ready(in_ready),
    .num_q(num_q), .den_q(den_q), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand set, reports in_ready right after the accept edge and
  // the number of edges from the accept edge until out_valid is seen.
  task automatic do_op(input logic [7:0] n, input logic [7:0] d, input logic [7:0] gg,
                       output logic rdy_after, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL in_ready_wait: in_ready=%0b required 1", in_ready);
    end
    num = n; den = d; g = gg; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rdy_after = in_ready;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (out_valid && lat == 0) lat = 1;
    else if (out_valid) lat = lat;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; num = 8'd12; den = 8'd4; g = 8'd4;
    tick(); tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
    end
    total++;
    if (num_q !== 8'd0 || den_q !== 8'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: num_q=%0d den_q=%0d err=%0b required 0 0 0", num_q, den_q, err);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_ready: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic ra; int lat;
    do_op(8'd12, 8'd4, 8'd4, ra, lat);
    total++;
    if (ra !== 1'b0) begin
      bad++;
      $display("FAIL basic_ready_fall: in_ready=%0b required 0", ra);
    end
    total++;
    if (lat != 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d edges required 8", lat);
    end
    total++;
    if (num_q !== 8'd3 || den_q !== 8'd1 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: %0d/%0d err=%0b required 3/1 err=0", num_q, den_q, err);
    end
    consume();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_handshake: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_values();
    // {num, den, g, num_q, den_q, err}
    logic [7:0] tv [5][6];
    logic ra; int lat;
    tv[0] = '{8'd8,   8'd3,   8'd1,   8'd8, 8'd3, 8'd0};
    tv[1] = '{8'd255, 8'd85,  8'd85,  8'd3, 8'd1, 8'd0};
    tv[2] = '{8'd0,   8'd5,   8'd5,   8'd0, 8'd1, 8'd0};
    tv[3] = '{8'd255, 8'd255, 8'd255, 8'd1, 8'd1, 8'd0};
    tv[4] = '{8'd254, 8'd127, 8'd127, 8'd2, 8'd1, 8'd0};
    for (int i = 0; i < 5; i++) begin
      do_op(tv[i][0], tv[i][1], tv[i][2], ra, lat);
      total++;
      if (num_q !== tv[i][3] || den_q !== tv[i][4] || err !== tv[i][5][0] || lat != 8) begin
        bad++;
        $display("FAIL values_%0d: %0d/%0d err=%0b lat=%0d required %0d/%0d err=%0b lat=8",
                 i, num_q, den_q, err, lat, tv[i][3], tv[i][4], tv[i][5][0]);
      end
      consume();
    end
  endtask

  task automatic test_err();
    logic ra; int lat;
    do_op(8'd5, 8'd7, 8'd0, ra, lat);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL g0_latency: got %0d edges required 1", lat);
    end
    total++;
    if (num_q !== 8'd5 || den_q !== 8'd7 || err !== 1'b1) begin
      bad++;
      $display("FAIL g0_result: %0d/%0d err=%0b required 5/7 err=1", num_q, den_q, err);
    end
    consume();
    do_op(8'd10, 8'd6, 8'd3, ra, lat);
    total++;
    if (num_q !== 8'd3 || den_q !== 8'd2 || err !== 1'b1) begin
      bad++;
      $display("FAIL rem_err: %0d/%0d err=%0b required 3/2 err=1", num_q, den_q, err);
    end
    consume();
    // Remainder only on the den side must also flag.
    do_op(8'd6, 8'd7, 8'd3, ra, lat);
    total++;
    if (num_q !== 8'd2 || den_q !== 8'd2 || err !== 1'b1) begin
      bad++;
      $display("FAIL rem_err_den: %0d/%0d err=%0b required 2/2 err=1", num_q, den_q, err);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic ra; int lat; int unstable = 0;
    do_op(8'd12, 8'd4, 8'd4, ra, lat);
    // A different operand set offered during DONE must be ignored.
    num = 8'd9; den = 8'd6; g = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || in_ready || num_q !== 8'd3 || den_q !== 8'd1 || err) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL stall_stable: %0d unstable cycles required 0 (now %0d/%0d v=%0b r=%0b)",
               unstable, num_q, den_q, out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || num_q !== 8'd3 || den_q !== 8'd1) begin
      bad++;
      $display("FAIL stall_no_accept: in_ready=%0b q=%0d/%0d required 1 3/1", in_ready, num_q, den_q);
    end
  endtask

  task automatic test_reset_mid();
    logic ra; int lat; int seen = 0;
    num = 8'd12; den = 8'd4; g = 8'd4; in_valid = 1'b1;
    tick();                      // accept edge
    in_valid = 1'b0;
    tick(); tick(); tick();      // DIV steps 1..3
    rst = 1'b1;
    tick();                      // reset on what would be step 4
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || num_q !== 8'd0 || den_q !== 8'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: v=%0b %0d/%0d err=%0b required 0 0/0 0", out_valid, num_q, den_q, err);
    end
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_ready: in_ready=%0b required 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_ghost: out_valid seen %0d cycles required 0", seen);
    end
    do_op(8'd9, 8'd6, 8'd3, ra, lat);
    total++;
    if (num_q !== 8'd3 || den_q !== 8'd2 || err !== 1'b0 || lat != 8) begin
      bad++;
      $display("FAIL midreset_fresh: %0d/%0d err=%0b lat=%0d required 3/2 err=0 lat=8", num_q, den_q, err, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    out_ready = 1'b1;
    num = 8'd9; den = 8'd6; g = 8'd3; in_valid = 1'b1;
    for (int c = 0; c < 40 && second < 0; c++) begin
      @(posedge clk);
      if (in_valid && in_ready) begin
        if (first < 0) first = c; else second = c;
      end
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (first < 0 || second - first != 10) begin
      bad++;
      $display("FAIL throughput: accepts at %0d and %0d required spacing 10", first, second);
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
